// File: rtl/fifo_pkg.sv
// Shared types and constants for the async FIFO write side and its write-port arbiter.
package fifo_pkg;

  localparam int unsigned FIFO_DW       = 8;
  localparam int unsigned FIFO_N        = 4;
  localparam int unsigned ARB_MAX_BURST = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Ceiling log2, floored at 1 so that single-value fields stay legal vectors.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 31) && ((32'd1 << r) < v)) begin
      r = r + 1;
    end
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2_f(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  localparam int unsigned W2 = 2 * N;

  logic [W2-1:0] req_dbl;
  logic [W2-1:0] mask;
  logic [W2-1:0] masked;
  logic          found;

  // Doubling the request vector turns the wrap into a plain lowest-set-bit search.
  always_comb begin
    req_dbl = {req, req};
    mask    = '0;
    for (int unsigned i = 0; i < W2; i++) begin
      mask[i] = (i >= 32'(ptr));
    end
    masked = req_dbl & mask;
    valid  = |req;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < W2; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx   = IW'((i >= N) ? (i - N) : i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-atomic arbiter sharing the async FIFO write port among N requesters.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int unsigned N         = FIFO_N,
  parameter  int unsigned DW        = FIFO_DW,
  parameter  int unsigned MAX_BURST = ARB_MAX_BURST,
  localparam int unsigned IW        = clog2_f(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] data,
  input  logic [N-1:0]    last,
  output logic [N-1:0]    ready,
  input  logic            full,
  output logic            w_en,
  output logic [DW-1:0]   w_data,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  localparam int unsigned    CW       = clog2_f(MAX_BURST);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0]  LAST_ID  = IW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic          req_g;
  logic          last_g;
  logic [DW-1:0] data_g;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          beat;

  rr_pick #(.N(N)) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Select the current grantee's request, last marker and beat data.
  always_comb begin
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_id_q == IW'(i)) begin
        req_g  = req[i];
        last_g = last[i];
        data_g = data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Next-state and beat handshake; the write happens in the same cycle as the accept.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    ready      = '0;
    beat       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        for (int unsigned i = 0; i < N; i++) begin
          ready[i] = (grant_id_q == IW'(i)) & ~full;
        end
        beat = req_g & ~full;
        if (beat) begin
          if (last_g || (beat_cnt_q == CNT_LAST)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = (grant_id_q == LAST_ID) ? '0 : (grant_id_q + IW'(1));
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_en     = beat;
  assign w_data   = data_g;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(ready));
  a_wen_in_grant: assert property (@(posedge clk) disable iff (!reset) w_en |-> busy);
  a_cnt_bounded:  assert property (@(posedge clk) disable iff (!reset) beat_cnt_q <= CNT_LAST);

endmodule
